// File: rtl/pic_pkg.sv
// Shared definitions for the 8259 command sequencer: init FSM states,
// command-word bit positions and OCW2 R/SL/EOI codes.
package pic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } pic_state_t;

    // A0=0 writes: D4 selects ICW1, otherwise D3 selects OCW3 over OCW2
    localparam int CMD_ICW1_BIT = 4;
    localparam int CMD_OCW3_BIT = 3;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_LTIM = 3;

    localparam int ICW4_UPM  = 0;
    localparam int ICW4_AEOI = 1;
    localparam int ICW4_MS   = 2;
    localparam int ICW4_BUF  = 3;
    localparam int ICW4_SFNM = 4;

    localparam int OCW3_RIS  = 0;
    localparam int OCW3_RR   = 1;
    localparam int OCW3_P    = 2;
    localparam int OCW3_SMM  = 5;
    localparam int OCW3_ESMM = 6;

    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_S_EOI        = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_S_EOI    = 3'b111;

endpackage

// File: rtl/pic_cmd_sequencer_if.sv
// CPU write bus from the read/write logic into the command sequencer.
interface pic_cmd_sequencer_if;
    // WR_ENABLE is a one-cycle strobe qualifying A0/DATA_IN; there is no
    // backpressure, so every strobe is consumed on the rising edge it is seen.
    logic       WR_ENABLE;
    logic       A0;
    logic [7:0] DATA_IN;

    modport master (output WR_ENABLE, A0, DATA_IN);
    modport slave  (input  WR_ENABLE, A0, DATA_IN);
endinterface

// File: rtl/pic_ocw2_decode.sv
// Maps the OCW2 R/SL/EOI field onto the command enables it requests.
module pic_ocw2_decode
    import pic_pkg::*;
(
    input  logic [2:0] code,
    output logic       eoi_en,
    output logic       seoi_en,
    output logic       rot_en,
    output logic       prio_en,
    output logic       rot_aeoi_set,
    output logic       rot_aeoi_clr
);

    always_comb begin
        eoi_en       = 1'b0;
        seoi_en      = 1'b0;
        rot_en       = 1'b0;
        prio_en      = 1'b0;
        rot_aeoi_set = 1'b0;
        rot_aeoi_clr = 1'b0;
        case (code)
            OCW2_ROT_AEOI_CLR: rot_aeoi_clr = 1'b1;
            OCW2_NS_EOI:       eoi_en       = 1'b1;
            OCW2_NOP:          ;
            OCW2_S_EOI:        seoi_en      = 1'b1;
            OCW2_ROT_AEOI_SET: rot_aeoi_set = 1'b1;
            OCW2_ROT_NS_EOI: begin
                eoi_en = 1'b1;
                rot_en = 1'b1;
            end
            OCW2_SET_PRIO:     prio_en      = 1'b1;
            OCW2_ROT_S_EOI: begin
                seoi_en = 1'b1;
                rot_en  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pic_cmd_sequencer.sv
// 8259 command-word sequencer: walks ICW1-ICW4 initialisation, holds the
// configuration registers and issues registered one-cycle OCW2/OCW3 pulses.
module pic_cmd_sequencer
    import pic_pkg::*;
#(
    parameter int                NUM_IR   = 8,
    parameter logic [NUM_IR-1:0] RST_MASK = '0,
    localparam int               LVL_W    = $clog2(NUM_IR)
) (
    input  logic              CLK,
    input  logic              RST,
    pic_cmd_sequencer_if.slave bus,
    output logic              init_done,
    output logic              LEVEL,
    output logic              sngl,
    output logic [4:0]        vector_base,
    output logic [7:0]        cascade_cfg,
    output logic              uPM,
    output logic              AEOI,
    output logic              MS,
    output logic              BUF,
    output logic              SFNM,
    output logic [NUM_IR-1:0] interrupt_mask,
    output logic              eoi_pulse,
    output logic              seoi_pulse,
    output logic [LVL_W-1:0]  eoi_level,
    output logic              rotate_eoi,
    output logic              rot_on_aeoi,
    output logic              prio_pulse,
    output logic              read_isr,
    output logic              poll_pulse,
    output logic              smm,
    output pic_state_t        state_dbg
);

    pic_state_t state, state_nxt;
    logic       ic4;

    logic [7:0] d;
    logic       is_icw1, is_ocw2, is_ocw3, is_data, in_ready;

    assign d        = bus.DATA_IN;
    assign is_icw1  = bus.WR_ENABLE & ~bus.A0 &  d[CMD_ICW1_BIT];
    assign is_ocw2  = bus.WR_ENABLE & ~bus.A0 & ~d[CMD_ICW1_BIT] & ~d[CMD_OCW3_BIT];
    assign is_ocw3  = bus.WR_ENABLE & ~bus.A0 & ~d[CMD_ICW1_BIT] &  d[CMD_OCW3_BIT];
    assign is_data  = bus.WR_ENABLE &  bus.A0;
    assign in_ready = (state == ST_READY);

    logic eoi_en, seoi_en, rot_en, prio_en, rot_aeoi_set, rot_aeoi_clr;

    pic_ocw2_decode u_ocw2_decode (
        .code         (d[7:5]),
        .eoi_en       (eoi_en),
        .seoi_en      (seoi_en),
        .rot_en       (rot_en),
        .prio_en      (prio_en),
        .rot_aeoi_set (rot_aeoi_set),
        .rot_aeoi_clr (rot_aeoi_clr)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // ICW1 restarts initialisation from any state, even mid-sequence
    always_comb begin
        state_nxt = state;
        if (is_icw1) begin
            state_nxt = ST_WAIT_ICW2;
        end else if (is_data) begin
            case (state)
                ST_WAIT_ICW2: begin
                    if (sngl) state_nxt = ic4 ? ST_WAIT_ICW4 : ST_READY;
                    else      state_nxt = ST_WAIT_ICW3;
                end
                ST_WAIT_ICW3: state_nxt = ic4 ? ST_WAIT_ICW4 : ST_READY;
                ST_WAIT_ICW4: state_nxt = ST_READY;
                default:      state_nxt = state;
            endcase
        end
    end

    always_comb begin
        init_done = (state == ST_READY);
        state_dbg = state;
    end

    // Configuration registers; vector_base and cascade_cfg survive a re-init
    // until the new ICW2/ICW3 overwrites them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            LEVEL          <= 1'b0;
            sngl           <= 1'b0;
            ic4            <= 1'b0;
            vector_base    <= '0;
            cascade_cfg    <= '0;
            uPM            <= 1'b0;
            AEOI           <= 1'b0;
            MS             <= 1'b0;
            BUF            <= 1'b0;
            SFNM           <= 1'b0;
            interrupt_mask <= RST_MASK;
            eoi_level      <= '0;
            rot_on_aeoi    <= 1'b0;
            read_isr       <= 1'b0;
            smm            <= 1'b0;
        end else if (is_icw1) begin
            LEVEL          <= d[ICW1_LTIM];
            sngl           <= d[ICW1_SNGL];
            ic4            <= d[ICW1_IC4];
            uPM            <= 1'b0;
            AEOI           <= 1'b0;
            MS             <= 1'b0;
            BUF            <= 1'b0;
            SFNM           <= 1'b0;
            interrupt_mask <= RST_MASK;
            rot_on_aeoi    <= 1'b0;
            read_isr       <= 1'b0;
            smm            <= 1'b0;
        end else begin
            if (is_data) begin
                case (state)
                    ST_WAIT_ICW2: vector_base <= d[7:3];
                    ST_WAIT_ICW3: cascade_cfg <= d;
                    ST_WAIT_ICW4: begin
                        uPM  <= d[ICW4_UPM];
                        AEOI <= d[ICW4_AEOI];
                        MS   <= d[ICW4_MS];
                        BUF  <= d[ICW4_BUF];
                        SFNM <= d[ICW4_SFNM];
                    end
                    ST_READY:     interrupt_mask <= d[NUM_IR-1:0];
                    default: ;
                endcase
            end
            if (in_ready && is_ocw2) begin
                if (seoi_en || prio_en) eoi_level   <= d[LVL_W-1:0];
                if (rot_aeoi_set)       rot_on_aeoi <= 1'b1;
                else if (rot_aeoi_clr)  rot_on_aeoi <= 1'b0;
            end
            if (in_ready && is_ocw3) begin
                if (d[OCW3_RR])   read_isr <= d[OCW3_RIS];
                if (d[OCW3_ESMM]) smm      <= d[OCW3_SMM];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            eoi_pulse  <= 1'b0;
            seoi_pulse <= 1'b0;
            rotate_eoi <= 1'b0;
            prio_pulse <= 1'b0;
            poll_pulse <= 1'b0;
        end else begin
            eoi_pulse  <= in_ready & is_ocw2 & eoi_en;
            seoi_pulse <= in_ready & is_ocw2 & seoi_en;
            rotate_eoi <= in_ready & is_ocw2 & rot_en;
            prio_pulse <= in_ready & is_ocw2 & prio_en;
            poll_pulse <= in_ready & is_ocw3 & d[OCW3_P];
        end
    end

endmodule
